pixel_skew_feeder: RTL and testbench
====================================

# pixel_skew_feeder

Input-side counterpart to the output normalizer of the systolic brightness filter. Accepts a stream of unsigned 8-bit pixels and packs them into rows of LANES pixels. Widens each pixel to a signed OUT_WIDTH accumulator-domain value and injects it into the systolic array with diagonal skew: lane i is delayed i cycles relative to lane 0. Handles partial final rows and signals frame completion once the skew pipeline has drained.

## Interface
- LANES, 4, number of systolic array rows fed (≥2)
- PIX_WIDTH, 8, input pixel width (unsigned)
- OUT_WIDTH, 24, per-lane output width (signed, two's complement)
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_pixel/in_last valid
- in_ready  output  1  registered; pixel accepted when in_valid && in_ready
- in_pixel  input  PIX_WIDTH  pixel value
- in_last  input  1  qualifies accepted pixel as last of frame
- out_valid  output  LANES  per-lane valid; bit i for lane i
- out_data  output  LANES*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- frame_done  output  1  one-cycle pulse after final lane of frame emitted
- busy  output  1  high when row buffer non-empty or any skew stage valid

## Operation
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - frame_done = 0
  - busy = 0
  - row count = 0
  - state = FILL
- Widening: out value = zero-extension of pixel to OUT_WIDTH. Result is always in 0..2^PIX_WIDTH−1 and never negative. 8'hFF → 24'h0000FF.
- Row buffer: accepted pixels fill slots 0..LANES−1 in arrival order.
- Issue: on acceptance of slot LANES−1, or of any slot with in_last, the whole row is copied into the skew pipeline and the row count resets to 0.
  - Unfilled slots are padded per Configuration.
  - The buffer is then free the next cycle (double-buffered), so back-to-back rows never stall.
- Skew pipeline: lane i has i+1 register stages; there is no downstream backpressure.
- States:
  - FILL: in_ready = 1; accept pixels.
    - Issue with in_last → DRAIN.
    - Issue without in_last → stay in FILL.
  - DRAIN: in_ready = 0; counter runs LANES cycles, then → DONE.
  - DONE: in_ready = 0; frame_done = 1 for one cycle, then → FILL.
- While in_ready = 0, in_valid is ignored; upstream holds its data.
- Gaps in in_valid during FILL only delay the issue; partial rows are held indefinitely.
- Reset mid-operation: the next cycle shows reset values. The partial row and all skew contents are discarded, and no frame_done is produced.

## Timing
- Issue-triggering pixel accepted at cycle t:
  - lane i: out_valid[i] = 1 and out_data lane i valid at cycle t+1+i, for exactly one cycle.
- Consecutive rows issued at cycles t and t+LANES give each lane valid once every LANES cycles, with no overlap.
- Frame end, when the issuing pixel carries in_last at cycle t:
  - in_ready = 0 for cycles t+1 … t+LANES+1.
  - frame_done = 1 at cycle t+LANES+1, the cycle after the last lane (LANES−1) is valid at t+LANES.
  - in_ready = 1 again at cycle t+LANES+2.
- busy:
  - rises the cycle after the first pixel of a row is accepted;
  - falls the cycle after the last skew stage empties.
- Zero combinational paths from inputs to outputs.

## Configuration
- PIXEL_FEEDER_PAD_REPLICATE_EN:
  - Defined: unfilled slots of a partial final row are padded with the last accepted pixel of that row.
  - Undefined (default): unfilled slots are padded with 0.
- In both cases the padded lanes assert out_valid at their normal skewed cycle.

## Test plan
All scenarios use LANES = 4.
- Single full row: pixels 10, 20, 30, 40 accepted at cycles 0–3 with in_last on 40.
  - lane0 = 24'h00000A @4, lane1 = 24'h000014 @5, lane2 = 24'h00001E @6, lane3 = 24'h000028 @7.
  - frame_done @8; in_ready low cycles 4–8, high @9.
- Partial last row: 200, 255 accepted at cycles 0–1 with in_last on 255.
  - lane0 = 200 @2, lane1 = 255 @3.
  - lane2 and lane3 = 0 @4 and @5 (255 with the macro defined).
  - frame_done @6.
- Back-to-back: 8 pixels 1..8 on consecutive cycles 0–7, in_last on 8.
  - lane0 = 1 @4 and 5 @8; lane3 = 4 @7 and 8 @11.
  - in_ready stays high through cycle 7.
- Gapped input: in_valid toggles every other cycle for 4 pixels.
  - Issue occurs only on the 4th acceptance; skew offsets are unchanged relative to it.
- Reset mid-row: 2 pixels accepted, then rst for 1 cycle, then full row 9, 9, 9, 9.
  - No output from the discarded pixels; lanes 0–3 = 9 with the standard skew; exactly one frame_done.
- Extremes: pixels 0, 255, 0, 255.
  - Outputs 24'h000000 and 24'h0000FF; the MSB of every lane is never 1.

Source files
------------

// File: rtl/pixel_skew_feeder.sv
// pixel_skew_feeder: packs an unsigned pixel stream into rows of LANES pixels,
// zero-extends each pixel to OUT_WIDTH and injects the row into a systolic array
// with diagonal skew (lane i delayed i cycles relative to lane 0).
// Build option PIXEL_FEEDER_PAD_REPLICATE_EN: when defined, unfilled slots of a
// partial final row repeat the last accepted pixel; otherwise they are zero.
//
// state | meaning
// FILL  | accepting pixels into the row buffer
// DRAIN | last row issued, waiting LANES cycles for the skew to empty
// DONE  | frame_done pulse, input still held off
module pixel_skew_feeder #(
    parameter int LANES     = 4,
    parameter int PIX_WIDTH = 8,
    parameter int OUT_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_WIDTH-1:0]       in_pixel,
    input  logic                       in_last,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*OUT_WIDTH-1:0] out_data,
    output logic                       frame_done,
    output logic                       busy
);

    localparam int            CW        = $clog2(LANES);
    localparam logic [CW-1:0] LAST_SLOT = CW'(LANES - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          drain_cnt_q;
    logic                   in_ready_q;
    logic                   frame_done_q;
    logic [CW-1:0]          slot_q;
    logic [PIX_WIDTH-1:0]   row_q [LANES];
    logic [PIX_WIDTH-1:0]   row_d [LANES];
    logic [PIX_WIDTH-1:0]   pad_val;
    logic [LANES-1:0]       lane_busy;
    logic                   accept;
    logic                   issue;

    assign accept = in_valid && in_ready_q;
    assign issue  = accept && (in_last || (slot_q == LAST_SLOT));

    // Pad value for slots beyond the issuing pixel of a partial row
    always_comb begin
`ifdef PIXEL_FEEDER_PAD_REPLICATE_EN
        pad_val = in_pixel;
`else
        pad_val = '0;
`endif
    end

    // Row as it enters the skew pipeline: stored slots, the issuing pixel, then padding
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            if (CW'(k) < slot_q) begin
                row_d[k] = row_q[k];
            end else if (CW'(k) == slot_q) begin
                row_d[k] = in_pixel;
            end else begin
                row_d[k] = pad_val;
            end
        end
    end

    // Row buffer fill; the issuing pixel bypasses the buffer so it is free next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                row_q[k] <= '0;
            end
        end else if (accept) begin
            if (issue) begin
                slot_q <= '0;
            end else begin
                row_q[slot_q] <= in_pixel;
                slot_q        <= slot_q + 1'b1;
            end
        end
    end

    // Frame sequencing with registered in_ready and frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            in_ready_q   <= 1'b1;
            frame_done_q <= 1'b0;
            drain_cnt_q  <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (issue && in_last) begin
                        state_q     <= DRAIN;
                        in_ready_q  <= 1'b0;
                        drain_cnt_q <= LAST_SLOT;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= FILL;
                    frame_done_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end
                default: begin
                    state_q      <= FILL;
                    frame_done_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [i:0]           v_q;
        logic [PIX_WIDTH-1:0] d_q [i+1];

        // Lane i skew: i+1 stages; data is zero while not carrying a valid pixel
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
                for (int j = 0; j <= i; j++) begin
                    d_q[j] <= '0;
                end
            end else begin
                v_q[0] <= issue;
                d_q[0] <= issue ? row_d[i] : '0;
                for (int j = 1; j <= i; j++) begin
                    v_q[j] <= v_q[j-1];
                    d_q[j] <= d_q[j-1];
                end
            end
        end

        assign out_valid[i]                        = v_q[i];
        assign out_data[i*OUT_WIDTH +: OUT_WIDTH]  = {{(OUT_WIDTH-PIX_WIDTH){1'b0}}, d_q[i]};
        assign lane_busy[i]                        = |v_q;
    end

    assign in_ready   = in_ready_q;
    assign frame_done = frame_done_q;
    assign busy       = (slot_q != '0) || (|lane_busy);

endmodule

// File: tb/tb_pixel_skew_feeder.sv
// Testbench for pixel_skew_feeder: directed scenarios plus randomized frames
// compared against a row/skew reference model built from acceptance events.
module tb_pixel_skew_feeder;

    localparam int LANES = 4;
    localparam int PW    = 8;
    localparam int OW    = 24;
    localparam int NC    = 512;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [PW-1:0]         in_pixel;
    logic                  in_last;
    logic [LANES-1:0]      out_valid;
    logic [LANES*OW-1:0]   out_data;
    logic                  frame_done;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    logic [LANES-1:0] obs_v   [NC];
    logic [OW-1:0]    obs_d   [NC][LANES];
    logic             obs_fd  [NC];
    logic             obs_rdy [NC];
    logic             obs_busy[NC];

    logic [LANES-1:0] exp_v   [NC];
    logic [OW-1:0]    exp_d   [NC][LANES];
    logic             exp_fd  [NC];
    logic             exp_rdy [NC];
    logic             exp_busy[NC];

    int            acc_cyc [$];
    logic [PW-1:0] acc_pix [$];
    logic          acc_last[$];

    pixel_skew_feeder #(.LANES(LANES), .PIX_WIDTH(PW), .OUT_WIDTH(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_pixel = '0;
        step();
        rst = 1'b0;
    endtask

    // Drive a pixel list (mode 0: back to back, 1: every other cycle, 2: random gaps)
    // and record the outputs seen in each cycle plus every acceptance.
    task automatic play(input logic [PW-1:0] pix[$], input logic lst[$], input int mode, input int ncyc);
        int idx = 0;
        bit go;
        acc_cyc.delete();
        acc_pix.delete();
        acc_last.delete();
        for (int k = 0; k < ncyc; k++) begin
            obs_v[k]    = out_valid;
            obs_fd[k]   = frame_done;
            obs_rdy[k]  = in_ready;
            obs_busy[k] = busy;
            for (int i = 0; i < LANES; i++) obs_d[k][i] = out_data[i*OW +: OW];
            go = (idx < pix.size());
            if (mode == 1) go = go && (k % 2 == 0);
            else if (mode == 2) go = go && ($urandom_range(99) >= 30);
            in_valid = go;
            in_pixel = go ? pix[idx] : '0;
            in_last  = go ? lst[idx] : 1'b0;
            if (go && in_ready) begin
                acc_cyc.push_back(k);
                acc_pix.push_back(pix[idx]);
                acc_last.push_back(lst[idx]);
                idx++;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'($urandom_range(255));
        in_last  = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || out_valid !== '0) begin errors++; $display("FAIL reset_idle got busy %b valid %b exp 0 0", busy, out_valid); end
    endtask

    task automatic test_full_row();
        logic [PW-1:0] p[$];
        logic          l[$];
        p = '{8'd10, 8'd20, 8'd30, 8'd40};
        l = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        play(p, l, 0, 12);
        for (int i = 0; i < LANES; i++) begin
            checks++; if (obs_v[4+i] !== LANES'(1 << i)) begin errors++; $display("FAIL full_valid lane %0d got %b exp %b", i, obs_v[4+i], LANES'(1 << i)); end
            checks++; if (obs_d[4+i][i] !== OW'(10 * (i + 1))) begin errors++; $display("FAIL full_data lane %0d got %h exp %h", i, obs_d[4+i][i], OW'(10 * (i + 1))); end
        end
        for (int c = 0; c < 12; c++) begin
            checks++; if (obs_fd[c] !== (c == 8)) begin errors++; $display("FAIL full_frame_done cyc %0d got %b exp %b", c, obs_fd[c], (c == 8)); end
            checks++; if (obs_rdy[c] !== !(c >= 4 && c <= 8)) begin errors++; $display("FAIL full_in_ready cyc %0d got %b exp %b", c, obs_rdy[c], !(c >= 4 && c <= 8)); end
        end
        checks++; if (obs_busy[1] !== 1'b1 || obs_busy[7] !== 1'b1 || obs_busy[8] !== 1'b0) begin
            errors++; $display("FAIL full_busy got %b%b%b exp 110", obs_busy[1], obs_busy[7], obs_busy[8]);
        end
    endtask

    task automatic test_partial_row();
        logic [PW-1:0] p[$];
        logic          l[$];
        logic [OW-1:0] pad;
        p = '{8'd200, 8'd255};
        l = '{1'b0, 1'b1};
`ifdef PIXEL_FEEDER_PAD_REPLICATE_EN
        pad = 24'd255;
`else
        pad = 24'd0;
`endif
        do_reset();
        play(p, l, 0, 10);
        checks++; if (obs_v[2] !== 4'b0001 || obs_d[2][0] !== 24'd200) begin errors++; $display("FAIL partial_lane0 got %b %h exp 0001 0000c8", obs_v[2], obs_d[2][0]); end
        checks++; if (obs_v[3] !== 4'b0010 || obs_d[3][1] !== 24'd255) begin errors++; $display("FAIL partial_lane1 got %b %h exp 0010 0000ff", obs_v[3], obs_d[3][1]); end
        checks++; if (obs_v[4] !== 4'b0100 || obs_d[4][2] !== pad) begin errors++; $display("FAIL partial_lane2 got %b %h exp 0100 %h", obs_v[4], obs_d[4][2], pad); end
        checks++; if (obs_v[5] !== 4'b1000 || obs_d[5][3] !== pad) begin errors++; $display("FAIL partial_lane3 got %b %h exp 1000 %h", obs_v[5], obs_d[5][3], pad); end
        checks++; if (obs_fd[6] !== 1'b1 || obs_fd[5] !== 1'b0 || obs_fd[7] !== 1'b0) begin errors++; $display("FAIL partial_frame_done got %b%b%b exp 010", obs_fd[5], obs_fd[6], obs_fd[7]); end
        checks++; if (obs_rdy[7] !== 1'b1 || obs_rdy[6] !== 1'b0) begin errors++; $display("FAIL partial_in_ready got %b%b exp 01", obs_rdy[6], obs_rdy[7]); end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] p[$];
        logic          l[$];
        p = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        play(p, l, 0, 16);
        checks++; if (acc_cyc.size() != 8 || acc_cyc[7] != 7) begin errors++; $display("FAIL b2b_accepts got %0d exp 8 by cyc 7", acc_cyc.size()); end
        for (int c = 0; c < 8; c++) begin
            checks++; if (obs_rdy[c] !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b exp 1", c, obs_rdy[c]); end
        end
        checks++; if (!obs_v[4][0] || obs_d[4][0] !== 24'd1) begin errors++; $display("FAIL b2b_lane0_a got %h exp 000001", obs_d[4][0]); end
        checks++; if (!obs_v[8][0] || obs_d[8][0] !== 24'd5) begin errors++; $display("FAIL b2b_lane0_b got %h exp 000005", obs_d[8][0]); end
        checks++; if (!obs_v[7][3] || obs_d[7][3] !== 24'd4) begin errors++; $display("FAIL b2b_lane3_a got %h exp 000004", obs_d[7][3]); end
        checks++; if (!obs_v[11][3] || obs_d[11][3] !== 24'd8) begin errors++; $display("FAIL b2b_lane3_b got %h exp 000008", obs_d[11][3]); end
        checks++; if (obs_fd[12] !== 1'b1) begin errors++; $display("FAIL b2b_frame_done got %b exp 1", obs_fd[12]); end
    endtask

    task automatic test_gapped();
        logic [PW-1:0] p[$];
        logic          l[$];
        p = '{8'd11, 8'd12, 8'd13, 8'd14};
        l = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        play(p, l, 1, 16);
        checks++; if (acc_cyc.size() != 4 || acc_cyc[3] != 6) begin errors++; $display("FAIL gap_accepts got %0d exp 4 ending cyc 6", acc_cyc.size()); end
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_v[c] !== ((c >= 7 && c <= 10) ? LANES'(1 << (c - 7)) : '0)) begin
                errors++; $display("FAIL gap_valid cyc %0d got %b", c, obs_v[c]);
            end
        end
        for (int i = 0; i < LANES; i++) begin
            checks++; if (obs_d[7+i][i] !== OW'(11 + i)) begin errors++; $display("FAIL gap_data lane %0d got %h exp %h", i, obs_d[7+i][i], OW'(11 + i)); end
        end
        checks++; if (obs_fd[11] !== 1'b1) begin errors++; $display("FAIL gap_frame_done got %b exp 1", obs_fd[11]); end
    endtask

    task automatic test_reset_mid_row();
        logic [PW-1:0] p[$];
        logic          l[$];
        int            nfd;
        int            nv;
        p = '{8'd9, 8'd9, 8'd9, 8'd9};
        l = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        in_valid = 1'b1; in_pixel = 8'd77; in_last = 1'b0;
        step();
        in_pixel = 8'd78;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_after got busy %b valid %b ready %b", busy, out_valid, in_ready); end
        play(p, l, 0, 14);
        nfd = 0; nv = 0;
        for (int c = 0; c < 14; c++) begin
            nfd += int'(obs_fd[c]);
            nv  += $countones(obs_v[c]);
        end
        checks++; if (nfd != 1 || obs_fd[8] !== 1'b1) begin errors++; $display("FAIL midrst_frame_done got %0d exp 1 at cyc 8", nfd); end
        checks++; if (nv != 4) begin errors++; $display("FAIL midrst_valid_count got %0d exp 4", nv); end
        for (int i = 0; i < LANES; i++) begin
            checks++; if (!obs_v[4+i][i] || obs_d[4+i][i] !== 24'd9) begin errors++; $display("FAIL midrst_lane %0d got %h exp 000009", i, obs_d[4+i][i]); end
        end
    endtask

    task automatic test_extremes();
        logic [PW-1:0] p[$];
        logic          l[$];
        p = '{8'd0, 8'd255, 8'd0, 8'd255};
        l = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        play(p, l, 0, 10);
        for (int i = 0; i < LANES; i++) begin
            checks++; if (!obs_v[4+i][i] || obs_d[4+i][i] !== ((i % 2 == 1) ? 24'h0000FF : 24'h000000)) begin
                errors++; $display("FAIL extreme_lane %0d got %h", i, obs_d[4+i][i]);
            end
            checks++; if (obs_d[4+i][i][OW-1] !== 1'b0) begin errors++; $display("FAIL extreme_msb lane %0d got 1 exp 0", i); end
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] p[$];
        logic          l[$];
        logic [PW-1:0] cur[$];
        logic [PW-1:0] padv;
        int            row_start;
        int            t;
        int            ncyc;
        ncyc = 420;
        for (int n = 0; n < 60; n++) begin
            p.push_back(8'($urandom_range(255)));
            l.push_back((n == 59) || ($urandom_range(5) == 0));
        end
        do_reset();
        play(p, l, 2, ncyc);
        checks++; if (acc_cyc.size() != 60) begin errors++; $display("FAIL rand_accepts got %0d exp 60", acc_cyc.size()); end
        for (int c = 0; c < NC; c++) begin
            exp_v[c] = '0; exp_fd[c] = 1'b0; exp_rdy[c] = 1'b1; exp_busy[c] = 1'b0;
            for (int i = 0; i < LANES; i++) exp_d[c][i] = '0;
        end
        row_start = 0;
        for (int n = 0; n < acc_cyc.size(); n++) begin
            t = acc_cyc[n];
            if (cur.size() == 0) row_start = t;
            cur.push_back(acc_pix[n]);
            if (cur.size() == LANES || acc_last[n]) begin
`ifdef PIXEL_FEEDER_PAD_REPLICATE_EN
                padv = acc_pix[n];
`else
                padv = '0;
`endif
                while (cur.size() < LANES) cur.push_back(padv);
                for (int i = 0; i < LANES; i++) begin
                    exp_v[t+1+i][i] = 1'b1;
                    exp_d[t+1+i][i] = OW'(cur[i]);
                end
                for (int c = row_start + 1; c <= t + LANES; c++) exp_busy[c] = 1'b1;
                if (acc_last[n]) begin
                    exp_fd[t+LANES+1] = 1'b1;
                    for (int c = t + 1; c <= t + LANES + 1; c++) exp_rdy[c] = 1'b0;
                end
                cur.delete();
            end
        end
        for (int c = 0; c < ncyc; c++) begin
            checks++; if (obs_v[c] !== exp_v[c]) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, obs_v[c], exp_v[c]); end
            checks++; if (obs_rdy[c] !== exp_rdy[c]) begin errors++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", c, obs_rdy[c], exp_rdy[c]); end
            checks++; if (obs_fd[c] !== exp_fd[c]) begin errors++; $display("FAIL rand_frame_done cyc %0d got %b exp %b", c, obs_fd[c], exp_fd[c]); end
            checks++; if (obs_busy[c] !== exp_busy[c]) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, obs_busy[c], exp_busy[c]); end
            for (int i = 0; i < LANES; i++) begin
                if (exp_v[c][i]) begin
                    checks++; if (obs_d[c][i] !== exp_d[c][i]) begin errors++; $display("FAIL rand_data cyc %0d lane %0d got %h exp %h", c, i, obs_d[c][i], exp_d[c][i]); end
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        in_last  = 1'b0;
        #1;
        test_reset();
        test_full_row();
        test_partial_row();
        test_back_to_back();
        test_gapped();
        test_reset_mid_row();
        test_extremes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
